// File: rtl/burst_error_injector.sv
// ---------------------------------------------------------------------------
// burst_error_injector
//   Streams clean codewords through a one-entry output register and, depending
//   on mode, flips a single bit or a short burst of bits chosen by a 32-bit
//   Galois LFSR (x^32+x^22+x^2+x+1, right shift). The LFSR steps once per
//   accepted word; the fields used for a word come from the LFSR value before
//   that step.
//
//   Optional feature macro: BURST_ERROR_INJECTOR_STATS_EN
//     defined   -> err_count is a saturating count of corrupted words
//     undefined -> err_count is tied to 0 and the counter is absent
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   in_valid     input word valid
//   in_ready     input word accepted when high together with in_valid
//   in_data      clean codeword [DATA_W]
//   mode         0/3 pass, 1 single-bit flip, 2 burst flip
//   seed_load    load seed into the LFSR on the next edge
//   seed         seed value (0 selects SEED)
//   out_valid    output word valid
//   out_ready    downstream ready
//   out_data     corrupted codeword [DATA_W]
//   burst_start  index of the first flipped bit
//   burst_len    number of bits in the burst span (0 = none)
//   err_count    saturating corrupted-word count
// ---------------------------------------------------------------------------

// Per-bit lane: decides whether bit IDX lies in the burst span and is flipped.
module burst_error_injector_lane #(
    parameter int IDX = 0
) (
    input  logic [8:0]  i_start,
    input  logic [4:0]  i_len,
    input  logic [15:0] i_taps,     // lfsr[31:16], interior flip pattern
    output logic        o_flip
);
    localparam logic [8:0] IDX9 = 9'(IDX);

    logic [8:0] w_off;
    logic [8:0] w_len9;
    logic       w_in_span;
    logic       w_end;

    assign w_off     = IDX9 - i_start;
    assign w_len9    = {4'b0, i_len};
    assign w_in_span = (IDX9 >= i_start) && (w_off < w_len9);
    // Both ends of the span are always flipped; interior bits follow the taps.
    assign w_end     = (w_off == 9'd0) || (w_off == w_len9 - 9'd1);
    assign o_flip    = w_in_span && (w_end || i_taps[w_off[3:0]]);
endmodule

module burst_error_injector #(
    parameter int          DATA_W    = 64,
    parameter int          MAX_BURST = 8,
    parameter logic [31:0] SEED      = 32'hACE12468
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [1:0]                mode,
    input  logic                      seed_load,
    input  logic [31:0]               seed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(DATA_W)-1:0] burst_start,
    output logic [4:0]                burst_len,
    output logic [15:0]               err_count
);
    localparam int          SW    = $clog2(DATA_W);
    localparam logic [31:0] TAPS  = 32'h8020_0003;
    localparam logic [7:0]  MOD_V = 8'(MAX_BURST - 1);

    logic [31:0]       r_lfsr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [SW-1:0]     r_start;
    logic [4:0]        r_len;

    logic              w_hs;
    logic              w_corrupt;
    logic [31:0]       w_lfsr_adv;
    logic [SW-1:0]     w_start;
    logic [7:0]        w_mod;
    logic [4:0]        w_rawlen;
    logic [8:0]        w_room;
    logic [4:0]        w_len;
    logic [4:0]        w_eff_len;
    logic [DATA_W-1:0] w_mask;

    assign in_ready  = !r_valid || out_ready;
    assign w_hs      = in_valid && in_ready;
    assign w_corrupt = (mode == 2'd1) || (mode == 2'd2);

    assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'h0);

    // DATA_W is a power of two no larger than 256, so lfsr[7:0] mod DATA_W
    // is just the low SW bits.
    assign w_start  = r_lfsr[SW-1:0];
    assign w_mod    = r_lfsr[15:8] % MOD_V;
    assign w_rawlen = 5'd2 + w_mod[4:0];
    // Clip so the burst never runs past the top bit. When clipped the room
    // is below rawlen (<= 16), so it fits in 5 bits.
    assign w_room   = 9'(DATA_W) - 9'(w_start);
    assign w_len    = (9'(w_rawlen) > w_room) ? w_room[4:0] : w_rawlen;
    // Single-bit mode is a burst of length one at the same start.
    assign w_eff_len = (mode == 2'd1) ? 5'd1 : w_len;

    for (genvar i = 0; i < DATA_W; i++) begin : g_lane
        burst_error_injector_lane #(.IDX(i)) u_lane (
            .i_start (9'(w_start)),
            .i_len   (w_eff_len),
            .i_taps  (r_lfsr[31:16]),
            .o_flip  (w_mask[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= SEED;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_start <= '0;
            r_len   <= '0;
        end else begin
            // A seed load overrides the step of a word accepted this cycle;
            // that word has already sampled the pre-load value.
            if (seed_load)
                r_lfsr <= (seed == 32'd0) ? SEED : seed;
            else if (w_hs)
                r_lfsr <= w_lfsr_adv;

            if (w_hs) begin
                r_valid <= 1'b1;
                r_data  <= in_data ^ (w_corrupt ? w_mask : '0);
                r_start <= w_corrupt ? w_start : '0;
                r_len   <= w_corrupt ? w_eff_len : 5'd0;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign burst_start = r_start;
    assign burst_len   = r_len;

`ifdef BURST_ERROR_INJECTOR_STATS_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= '0;
        else if (w_hs && w_corrupt && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 16'd0;
`endif
endmodule

// File: tb/tb_burst_error_injector.sv
module tb_burst_error_injector;
    localparam int          DW     = 64;
    localparam int          MB     = 8;
    localparam logic [31:0] SEED_P = 32'hACE12468;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    mode;
    logic          seed_load;
    logic [31:0]   seed;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [5:0]    burst_start;
    logic [4:0]    burst_len;
    logic [15:0]   err_count;

    burst_error_injector #(.DATA_W(DW), .MAX_BURST(MB), .SEED(SEED_P)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .seed_load(seed_load), .seed(seed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .burst_start(burst_start), .burst_len(burst_len), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int e_cnt = 0;

    typedef struct {
        logic [31:0] seed;
        logic [1:0]  mode;
        logic [63:0] din;
        logic [63:0] dout;
        int          st;
        int          ln;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] s);
        seed_load = 1'b1;
        seed      = s;
        step();
        seed_load = 1'b0;
    endtask

    function automatic int exp_cnt();
`ifdef BURST_ERROR_INJECTOR_STATS_EN
        return (e_cnt > 65535) ? 65535 : e_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] m_adv(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    // Reference corruption: direct walk over the span.
    function automatic logic [63:0] m_mask(input logic [31:0] l, input logic [1:0] md,
                                           output int st, output int ln);
        logic [63:0] m = '0;
        int s = int'(l[7:0]) % DW;
        int r = 2 + (int'(l[15:8]) % (MB - 1));
        int n = (r > DW - s) ? DW - s : r;
        st = 0;
        ln = 0;
        if (md == 2'd1) begin
            m[s] = 1'b1; st = s; ln = 1;
        end else if (md == 2'd2) begin
            for (int k = 0; k < n; k++)
                if (k == 0 || k == n - 1 || l[16+k]) m[s+k] = 1'b1;
            st = s; ln = n;
        end
        return m;
    endfunction

    // Streams n back-to-back words; the LFSR must currently hold l0.
    task automatic run_stream(input logic [31:0] l0, input logic [1:0] md,
                              input logic [63:0] din, input int n, input string nm);
        logic [31:0] l = l0;
        logic [63:0] m;
        int st, ln;
        in_valid = 1'b1; mode = md; in_data = din; out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            m = m_mask(l, md, st, ln);
            chk({nm, "_data"}, out_data, din ^ m);
            chk({nm, "_len"}, 64'(burst_len), 64'(ln));
            chk({nm, "_start"}, 64'(burst_start), 64'(st));
            if (md == 2'd1 || md == 2'd2) e_cnt++;
            l = m_adv(l);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] hand[3];
        int pc, lo, hi;
        logic ok;

        // seed, mode, in, expected out, start, len (hand-computed)
        tv[0]  = '{32'h0000_0005, 2'd1, 64'h0, 64'h0000_0000_0000_0020, 5, 1};
        tv[1]  = '{32'h0000_003F, 2'd2, 64'h0, 64'h8000_0000_0000_0000, 63, 1};
        tv[2]  = '{32'h0000_0000, 2'd2, 64'h0, 64'h0000_0500_0000_0000, 40, 3};
        tv[3]  = '{32'hFFFF_0638, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_FFFF_FFFF, 56, 8};
        tv[4]  = '{32'h0000_063C, 2'd2, 64'h0, 64'h9000_0000_0000_0000, 60, 4};
        tv[5]  = '{32'h0005_0A10, 2'd2, 64'h0, 64'h0000_0000_0015_0000, 16, 5};
        tv[6]  = '{32'h1234_5678, 2'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 0, 0};
        tv[7]  = '{32'h1234_5678, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 0, 0};
        tv[8]  = '{32'h0000_00FF, 2'd1, 64'h0, 64'h8000_0000_0000_0000, 63, 1};
        tv[9]  = '{32'h0000_0700, 2'd2, 64'h3, 64'h0, 0, 2};
        tv[10] = '{32'h0000_0001, 2'd1, 64'hF, 64'hD, 1, 1};
        hand[0] = 64'h6; hand[1] = 64'h18; hand[2] = 64'hC;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'd0;
        seed_load = 1'b0; seed = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_start", 64'(burst_start), 64'd0);
        chk("rst_len", 64'(burst_len), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Pass-through from reset LFSR state
        run_stream(SEED_P, 2'd0, 64'hDEAD_BEEF_CAFE_F00D, 10, "pass");
        chk("pass_err_count", 64'(err_count), 64'd0);

        // Burst properties from seed 1
        load(32'h1);
        in_valid = 1'b1; mode = 2'd2; in_data = '0;
        for (int i = 0; i < 100; i++) begin
            step();
            e_cnt++;
            if (i < 3) chk("seed1_hand", out_data, hand[i]);
            pc = 0; lo = -1; hi = -1;
            for (int b = 0; b < DW; b++)
                if (out_data[b]) begin
                    pc++;
                    if (lo < 0) lo = b;
                    hi = b;
                end
            ok = (pc >= 1) && (pc <= MB) && (burst_len >= 1) &&
                 (lo == int'(burst_start)) && (hi == int'(burst_start) + int'(burst_len) - 1);
            if (!ok)
                $display("burst_prop word %0d: data=%h start=%0d len=%0d", i, out_data, burst_start, burst_len);
            chk("burst_prop", 64'(ok), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("seed1_err_count", 64'(err_count), 64'(exp_cnt()));

        // Directed vector table
        foreach (tv[i]) begin
            load(tv[i].seed);
            in_valid = 1'b1; mode = tv[i].mode; in_data = tv[i].din;
            step();
            in_valid = 1'b0;
            if (tv[i].mode == 2'd1 || tv[i].mode == 2'd2) e_cnt++;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_data", i), out_data, tv[i].dout);
            chk($sformatf("vec%0d_start", i), 64'(burst_start), 64'(tv[i].st));
            chk($sformatf("vec%0d_len", i), 64'(burst_len), 64'(tv[i].ln));
            step();
            chk($sformatf("vec%0d_drain", i), 64'(out_valid), 64'd0);
        end
        chk("vec_err_count", 64'(err_count), 64'(exp_cnt()));

        // seed_load in the same cycle as a handshake
        load(32'h5);
        in_valid = 1'b1; mode = 2'd1; in_data = '0;
        seed_load = 1'b1; seed = 32'h3F;
        step();
        seed_load = 1'b0;
        chk("ldhs_word0", out_data, 64'h20);
        step();
        chk("ldhs_word1", out_data, 64'h8000_0000_0000_0000);
        in_valid = 1'b0;
        e_cnt += 2;
        step();

        // Backpressure hold and release
        load(32'h0005_0A10);
        in_valid = 1'b1; mode = 2'd2; in_data = '0; out_ready = 1'b0;
        step();
        e_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", out_data, 64'h0000_0000_0015_0000);
            chk("stall_start", 64'(burst_start), 64'd16);
            chk("stall_len", 64'(burst_len), 64'd5);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        step();
        e_cnt++;
        in_valid = 1'b0;
        chk("release_data", out_data, 64'h0000_0000_0000_0300);
        chk("release_start", 64'(burst_start), 64'd8);
        chk("release_len", 64'(burst_len), 64'd2);
        step();

        // Repeatability and zero seed
        load(32'h1234_5678);
        run_stream(32'h1234_5678, 2'd2, 64'h0F0F_0F0F_0F0F_0F0F, 8, "rep_a");
        load(32'h1234_5678);
        run_stream(32'h1234_5678, 2'd2, 64'h0F0F_0F0F_0F0F_0F0F, 8, "rep_b");
        load(32'h0);
        run_stream(SEED_P, 2'd2, 64'h0, 8, "seed0");
        chk("rep_err_count", 64'(err_count), 64'(exp_cnt()));

        // Reset while a word is held; reset outranks seed_load and handshake
        load(32'h3F);
        in_valid = 1'b1; mode = 2'd2; in_data = '0; out_ready = 1'b0;
        step();
        chk("prerst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1; seed_load = 1'b1; seed = 32'h3F;
        step();
        rst = 1'b0; seed_load = 1'b0; in_valid = 1'b0;
        e_cnt = 0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", out_data, 64'd0);
        chk("midrst_len", 64'(burst_len), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        run_stream(SEED_P, 2'd2, 64'h0, 3, "postrst");
        chk("final_err_count", 64'(err_count), 64'(exp_cnt()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
